// File: rtl/pl_io_pkg.sv
// Shared types and constants for the PL IO pattern sequencer.
package pl_io_pkg;

  localparam int LED_W = 3;
  localparam int OTH_W = 10;
  localparam int PAT_W = LED_W + OTH_W;

  typedef enum logic [1:0] {
    WALK1 = 2'd0,
    WALK0 = 2'd1,
    BLINK = 2'd2,
    COUNT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_PRESS = 2'd1,
    PS_LONG  = 2'd2
  } press_state_e;

  localparam logic [LED_W-1:0] LED_LOAD_WALK1 = 3'b001;
  localparam logic [LED_W-1:0] LED_LOAD_WALK0 = 3'b110;
  localparam logic [LED_W-1:0] LED_LOAD_BLINK = 3'b000;
  localparam logic [LED_W-1:0] LED_LOAD_COUNT = 3'b000;

  localparam logic [OTH_W-1:0] OTH_LOAD_WALK1 = 10'h001;
  localparam logic [OTH_W-1:0] OTH_LOAD_WALK0 = 10'h3FE;
  localparam logic [OTH_W-1:0] OTH_LOAD_BLINK = 10'h000;
  localparam logic [OTH_W-1:0] OTH_LOAD_COUNT = 10'h000;

  // Starting pattern for a mode, packed as {oth, led}
  function automatic logic [PAT_W-1:0] pattern_load(input mode_e m);
    case (m)
      WALK1:   return {OTH_LOAD_WALK1, LED_LOAD_WALK1};
      WALK0:   return {OTH_LOAD_WALK0, LED_LOAD_WALK0};
      BLINK:   return {OTH_LOAD_BLINK, LED_LOAD_BLINK};
      COUNT:   return {OTH_LOAD_COUNT, LED_LOAD_COUNT};
      default: return {OTH_LOAD_WALK1, LED_LOAD_WALK1};
    endcase
  endfunction

endpackage

// File: rtl/k2_press_decode.sv
// Synchronizes and debounces push-button K2, then classifies each press
// as short or long. Each press yields exactly one single-cycle event.
module k2_press_decode #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic k2,
  output logic short_ev,
  output logic long_ev
);
  import pl_io_pkg::*;

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic              sync1, sync2;
  logic [1:0]        sync_valid;
  logic              armed;
  logic              deb_level;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_accept, deb_fall, deb_rise;
  press_state_e      state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;

  // Two-flop synchronizer; presses are only armed once the real button has been seen released after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_valid <= 2'b00;
      armed      <= 1'b0;
    end else begin
      sync1      <= k2;
      sync2      <= sync1;
      sync_valid <= {sync_valid[0], 1'b1};
      armed      <= armed | (sync_valid[1] & sync2);
    end
  end

  assign deb_accept = (sync2 != deb_level) && (deb_cnt == DEB_MAX);
  assign deb_fall   = deb_accept & deb_level & armed;
  assign deb_rise   = deb_accept & ~deb_level;

  // Debounce: a new level is taken only after it has been stable for the full window
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (sync2 == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_MAX) begin
      deb_level <= sync2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Press FSM state and hold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PS_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
    end
  end

  // Press FSM next state and event pulses; reaching the long threshold wins over a same-cycle release
  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    short_ev = 1'b0;
    long_ev  = 1'b0;
    unique case (state)
      PS_IDLE: begin
        if (deb_fall) begin
          state_n = PS_PRESS;
          hold_n  = '0;
        end
      end
      PS_PRESS: begin
        if (hold_cnt == HOLD_MAX) begin
          long_ev = 1'b1;
          state_n = PS_LONG;
        end else if (deb_rise) begin
          short_ev = 1'b1;
          state_n  = PS_IDLE;
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      PS_LONG: begin
        if (deb_rise) state_n = PS_IDLE;
      end
      default: state_n = PS_IDLE;
    endcase
  end

endmodule

// File: rtl/pl_io_pattern_ctrl.sv
// PL IO bring-up sequencer: drives the J11 LEDs and J12/J13 header pins
// with one of four test patterns, auto-stepped or single-stepped from K2.
module pl_io_pattern_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int STEP_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k2,
  output logic [2:0] j11_led,
  output logic [7:0] j12,
  output logic [1:0] j13,
  output logic [1:0] mode,
  output logic       paused
);
  import pl_io_pkg::*;

  localparam int TMR_W = $clog2(STEP_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STEP_CYCLES - 1);

  logic             short_ev, long_ev;
  mode_e            mode_r, mode_next;
  logic             paused_r;
  logic [TMR_W-1:0] tmr;
  logic [LED_W-1:0] led_r;
  logic [OTH_W-1:0] oth_r;
  logic [PAT_W-1:0] step_pat, next_load;
  logic             tick;

  k2_press_decode #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_decode (
    .clk     (clk),
    .rst     (rst),
    .k2      (k2),
    .short_ev(short_ev),
    .long_ev (long_ev)
  );

  assign mode_next = mode_e'(mode_r + 2'd1);
  assign next_load = pattern_load(mode_next);
  assign tick      = !paused_r && (tmr == TMR_MAX);

  // Pattern after one step in the current mode; walks rotate LEDs and header bits independently
  always_comb begin
    step_pat = {oth_r, led_r};
    unique case (mode_r)
      WALK1, WALK0: step_pat = {oth_r[OTH_W-2:0], oth_r[OTH_W-1],
                                led_r[LED_W-2:0], led_r[LED_W-1]};
      BLINK:        step_pat = ~{oth_r, led_r};
      COUNT:        step_pat = {oth_r, led_r} + PAT_W'(1);
      default:      step_pat = {oth_r, led_r};
    endcase
  end

  // Mode, pause, timer and pattern registers; button events take priority over the timer tick
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r         <= WALK1;
      paused_r       <= 1'b0;
      tmr            <= '0;
      {oth_r, led_r} <= pattern_load(WALK1);
    end else if (short_ev) begin
      {oth_r, led_r} <= step_pat;
      paused_r       <= 1'b1;
      tmr            <= '0;
    end else if (long_ev) begin
      tmr <= '0;
      if (paused_r) begin
        paused_r <= 1'b0;
      end else begin
        mode_r         <= mode_next;
        {oth_r, led_r} <= next_load;
      end
    end else if (paused_r) begin
      tmr <= '0;
    end else if (tick) begin
      tmr            <= '0;
      {oth_r, led_r} <= step_pat;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  assign j11_led = led_r;
  assign j12     = oth_r[7:0];
  assign j13     = oth_r[9:8];
  assign mode    = mode_r;
  assign paused  = paused_r;

endmodule

// File: tb/tb_pl_io_pattern_ctrl.sv
// Directed bench for pl_io_pattern_ctrl. A main instance uses the short
// bench timing; a second instance with a 2-cycle step period reaches the
// COUNT wrap point in a reasonable number of cycles. Both share rst and k2.
module tb_pl_io_pattern_ctrl;

  typedef struct {
    int         n;
    logic       rst;
    logic       k2;
    logic       chk;
    logic [2:0] led;
    logic [9:0] oth;
    logic [1:0] mode;
    logic       paused;
  } vec_t;

  localparam int NVEC = 25;

  logic       clk;
  logic       rst;
  logic       k2;
  logic [2:0] led_m, led_f;
  logic [7:0] j12_m, j12_f;
  logic [1:0] j13_m, j13_f;
  logic [1:0] mode_m, mode_f;
  logic       paused_m, paused_f;

  int n_checks;
  int n_fail;
  vec_t vecs [NVEC];

  pl_io_pattern_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .STEP_CYCLES    (10)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .k2     (k2),
    .j11_led(led_m),
    .j12    (j12_m),
    .j13    (j13_m),
    .mode   (mode_m),
    .paused (paused_m)
  );

  pl_io_pattern_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .STEP_CYCLES    (2)
  ) u_fast (
    .clk    (clk),
    .rst    (rst),
    .k2     (k2),
    .j11_led(led_f),
    .j12    (j12_f),
    .j13    (j13_f),
    .mode   (mode_f),
    .paused (paused_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs just after an edge, run n edges, settle 1 time unit past the last edge
  task automatic applyStimulus(input logic r, input logic k, input int n);
    rst = r;
    k2  = k;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkDut(input bit fast, input string tag, input logic [2:0] led,
                          input logic [9:0] oth, input logic [1:0] md, input logic p);
    logic [2:0] g_led;
    logic [9:0] g_oth;
    logic [1:0] g_mode;
    logic       g_p;
    if (fast) begin
      g_led = led_f; g_oth = {j13_f, j12_f}; g_mode = mode_f; g_p = paused_f;
    end else begin
      g_led = led_m; g_oth = {j13_m, j12_m}; g_mode = mode_m; g_p = paused_m;
    end
    checkOutput({tag, " led"},    16'(g_led),  16'(led));
    checkOutput({tag, " oth"},    16'(g_oth),  16'(oth));
    checkOutput({tag, " mode"},   16'(g_mode), 16'(md));
    checkOutput({tag, " paused"}, 16'(g_p),    16'(p));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // n, rst, k2, chk, led, oth, mode, paused -- time is edges since reset release
    vecs[0]  = '{10, 1'b0, 1'b1, 1'b1, 3'b010, 10'h002, 2'd0, 1'b0}; // t10 first step
    vecs[1]  = '{10, 1'b0, 1'b1, 1'b1, 3'b100, 10'h004, 2'd0, 1'b0}; // t20
    vecs[2]  = '{15, 1'b0, 1'b1, 1'b1, 3'b001, 10'h008, 2'd0, 1'b0}; // t35 three steps
    vecs[3]  = '{3,  1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 2'd0, 1'b0}; // 3-cycle glitch
    vecs[4]  = '{7,  1'b0, 1'b1, 1'b1, 3'b010, 10'h010, 2'd0, 1'b0}; // t45 still running
    vecs[5]  = '{8,  1'b0, 1'b0, 1'b1, 3'b100, 10'h020, 2'd0, 1'b0}; // t53 tick during press
    vecs[6]  = '{7,  1'b0, 1'b1, 1'b1, 3'b001, 10'h040, 2'd0, 1'b1}; // t60 short: step+pause
    vecs[7]  = '{50, 1'b0, 1'b1, 1'b1, 3'b001, 10'h040, 2'd0, 1'b1}; // t110 frozen
    vecs[8]  = '{30, 1'b0, 1'b0, 1'b1, 3'b001, 10'h040, 2'd0, 1'b0}; // t140 long: resume
    vecs[9]  = '{5,  1'b0, 1'b1, 1'b1, 3'b001, 10'h040, 2'd0, 1'b0}; // t145
    vecs[10] = '{1,  1'b0, 1'b1, 1'b1, 3'b010, 10'h080, 2'd0, 1'b0}; // t146 step 10 after resume
    vecs[11] = '{30, 1'b0, 1'b0, 1'b1, 3'b110, 10'h3FE, 2'd1, 1'b0}; // t176 long: WALK0
    vecs[12] = '{5,  1'b0, 1'b1, 1'b1, 3'b110, 10'h3FE, 2'd1, 1'b0}; // t181
    vecs[13] = '{1,  1'b0, 1'b1, 1'b1, 3'b101, 10'h3FD, 2'd1, 1'b0}; // t182 timer restarted
    vecs[14] = '{6,  1'b0, 1'b1, 1'b1, 3'b101, 10'h3FD, 2'd1, 1'b0}; // t188
    vecs[15] = '{8,  1'b0, 1'b0, 1'b1, 3'b011, 10'h3FB, 2'd1, 1'b0}; // t196
    vecs[16] = '{6,  1'b0, 1'b1, 1'b1, 3'b110, 10'h3F7, 2'd1, 1'b1}; // t202 short on tick: one step
    vecs[17] = '{20, 1'b0, 1'b1, 1'b1, 3'b110, 10'h3F7, 2'd1, 1'b1}; // t222
    vecs[18] = '{21, 1'b0, 1'b0, 1'b1, 3'b110, 10'h3F7, 2'd1, 1'b1}; // t243 hold_cnt=15
    vecs[19] = '{2,  1'b1, 1'b0, 1'b1, 3'b001, 10'h001, 2'd0, 1'b0}; // t245 reset mid-press
    vecs[20] = '{40, 1'b0, 1'b0, 1'b1, 3'b010, 10'h010, 2'd0, 1'b0}; // t285 held, no event
    vecs[21] = '{10, 1'b0, 1'b1, 1'b1, 3'b100, 10'h020, 2'd0, 1'b0}; // t295 released
    vecs[22] = '{26, 1'b0, 1'b0, 1'b1, 3'b110, 10'h3FE, 2'd1, 1'b0}; // t321 new long press
    vecs[23] = '{4,  1'b0, 1'b0, 1'b0, 3'b000, 10'h000, 2'd0, 1'b0};
    vecs[24] = '{10, 1'b0, 1'b1, 1'b0, 3'b000, 10'h000, 2'd0, 1'b0};

    rst = 1'b1;
    k2  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkDut(1'b0, "reset", 3'b001, 10'h001, 2'd0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].k2, vecs[i].n);
      if (vecs[i].chk)
        checkDut(1'b0, $sformatf("vec%0d", i), vecs[i].led, vecs[i].oth,
                 vecs[i].mode, vecs[i].paused);
    end

    // COUNT wrap on the fast instance; COUNT is entered at t451 (value v at edge 451+2v)
    applyStimulus(1'b1, 1'b1, 2);
    checkDut(1'b1, "fast reset", 3'b001, 10'h001, 2'd0, 1'b0);
    checkDut(1'b0, "main reset", 3'b001, 10'h001, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8);
    checkDut(1'b1, "fast walk", 3'b010, 10'h010, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 30);
    checkDut(1'b1, "fast walk0", 3'b011, 10'h3FB, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 30);
    checkDut(1'b1, "fast blink", 3'b000, 10'h000, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 30);
    checkDut(1'b1, "fast count", 3'b010, 10'h000, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 16361);
    checkDut(1'b1, "count 1FF6", 3'b110, 10'h3FE, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 8);
    checkDut(1'b1, "count 1FFA", 3'b010, 10'h3FF, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 6);
    checkDut(1'b1, "count 1FFE", 3'b110, 10'h3FF, 2'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 6);
    checkDut(1'b1, "count 1FFF", 3'b111, 10'h3FF, 2'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 6);
    checkDut(1'b1, "count wrap", 3'b000, 10'h000, 2'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 26);
    checkDut(1'b1, "count resume", 3'b000, 10'h000, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 4);
    checkDut(1'b1, "count run", 3'b010, 10'h000, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 26);
    checkDut(1'b1, "mode wrap", 3'b001, 10'h001, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4);
    checkDut(1'b1, "mode wrap run", 3'b100, 10'h004, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
